timeout_timer: RTL and testbench

- Programmable, parametrised successor of the fixed-N enable counter, used for gate dwell, barrier-close and sensor-debounce timeouts in the parking controller.
- Counts clock cycles up to a terminal value that software or the FSM can load at run time.
- Supports one-shot and periodic modes, hold (pause), retrigger and abort.
- Emits a one-cycle expiry pulse and status flags.

---
 rtl/timeout_timer.sv | 80 ++++++++
 tb/tb_timeout_timer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/timeout_timer.sv
// Programmable cycle timer: one-shot or periodic, with hold, retrigger and abort.
// expired is a registered one-cycle pulse; status flags decode the registered state.
module timeout_timer #(
  parameter int BITS      = 8,
  parameter int DEFAULT_N = 30
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            hold,
  input  logic            periodic,
  input  logic            load,
  input  logic [BITS-1:0] load_value,
  output logic [BITS-1:0] count,
  output logic            busy,
  output logic            paused,
  output logic            done,
  output logic            expired
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [BITS-1:0] ONE       = BITS'(1);
  localparam logic [BITS-1:0] TERM_INIT = BITS'(DEFAULT_N);

  logic [1:0]      state;
  logic [BITS-1:0] term;
  logic            mode_periodic;
  logic            active;
  logic            at_term;

  assign active  = (state == RUN) || (state == PAUSED);
  assign at_term = (count == term - ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      term          <= TERM_INIT;
      mode_periodic <= 1'b0;
      expired       <= 1'b0;
    end else begin
      expired <= 1'b0;

      if (abort) begin
        state <= IDLE;
        count <= '0;
      end else if (start) begin
        state         <= hold ? PAUSED : RUN;
        count         <= '0;
        mode_periodic <= periodic;
      end else if (active) begin
        if (hold) begin
          state <= PAUSED;
        end else if (at_term) begin
          count   <= '0;
          expired <= 1'b1;
          state   <= mode_periodic ? RUN : DONE;
        end else begin
          count <= count + ONE;
          state <= RUN;
        end
      end

      // Terminal value is frozen while a run is in progress; a zero load means 1.
      if (load && !active) begin
        term <= (load_value == '0) ? ONE : load_value;
      end
    end
  end

  assign busy   = active;
  assign paused = (state == PAUSED);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_timeout_timer.sv
// Directed bench for timeout_timer: hand-computed vector table plus multi-cycle sequences.
module tb_timeout_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, hold, periodic, load;
  logic [7:0] load_value;
  logic [7:0] count;
  logic       busy, paused, done, expired;

  timeout_timer #(.BITS(8), .DEFAULT_N(30)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .hold(hold),
    .periodic(periodic), .load(load), .load_value(load_value),
    .count(count), .busy(busy), .paused(paused), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {count, busy, paused, done, expired}.
  wire [11:0] obs = {count, busy, paused, done, expired};

  typedef struct {
    logic       st, ab, hd, pe, ld;
    logic [7:0] lv;
    logic [11:0] exp_out;
  } vec_t;

  vec_t tbl[$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, ab, hd, pe, ld, input logic [7:0] lv);
    start = st; abort = ab; hold = hd; periodic = pe; load = ld; load_value = lv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic row(input logic st, ab, hd, pe, ld, input logic [7:0] lv,
                     input logic [7:0] c, input logic [3:0] f);
    vec_t v;
    v.st = st; v.ab = ab; v.hd = hd; v.pe = pe; v.ld = ld; v.lv = lv;
    v.exp_out = {c, f};
    tbl.push_back(v);
  endtask

  task automatic idle(input logic [7:0] c, input logic [3:0] f);
    row(0, 0, 0, 0, 0, 8'd0, c, f);
  endtask

  initial begin
    int cyc;

    // Flags are {busy, paused, done, expired}; table starts from DONE with term=30.
    row(0, 0, 0, 0, 1, 8'd5, 8'd0, 4'b0010);
    row(1, 0, 0, 1, 0, 8'd0, 8'd0, 4'b1000);
    for (int c = 1; c <= 4; c++) idle(8'(c), 4'b1000);
    idle(8'd0, 4'b1001);
    row(0, 0, 0, 0, 1, 8'd9, 8'd1, 4'b1000);
    for (int c = 2; c <= 4; c++) idle(8'(c), 4'b1000);
    idle(8'd0, 4'b1001);
    idle(8'd1, 4'b1000);
    row(0, 1, 0, 0, 0, 8'd0, 8'd0, 4'b0000);
    for (int c = 0; c < 6; c++) idle(8'd0, 4'b0000);
    row(1, 0, 0, 0, 1, 8'd0, 8'd0, 4'b1000);
    idle(8'd0, 4'b0011);
    idle(8'd0, 4'b0010);
    row(0, 0, 1, 0, 1, 8'd10, 8'd0, 4'b0010);
    row(1, 0, 0, 0, 0, 8'd0, 8'd0, 4'b1000);
    for (int c = 1; c <= 3; c++) idle(8'(c), 4'b1000);
    for (int c = 0; c < 4; c++) row(0, 0, 1, 0, 0, 8'd0, 8'd3, 4'b1100);
    for (int c = 4; c <= 9; c++) idle(8'(c), 4'b1000);
    idle(8'd0, 4'b0011);
    idle(8'd0, 4'b0010);
    row(1, 0, 0, 0, 0, 8'd0, 8'd0, 4'b1000);
    for (int c = 1; c <= 7; c++) idle(8'(c), 4'b1000);
    row(1, 0, 0, 0, 0, 8'd0, 8'd0, 4'b1000);
    for (int c = 1; c <= 9; c++) idle(8'(c), 4'b1000);
    idle(8'd0, 4'b0011);
    row(1, 0, 0, 1, 0, 8'd0, 8'd0, 4'b1000);
    for (int c = 1; c <= 9; c++) idle(8'(c), 4'b1000);
    row(1, 0, 0, 1, 0, 8'd0, 8'd0, 4'b1000);
    for (int c = 1; c <= 3; c++) idle(8'(c), 4'b1000);
    row(1, 1, 0, 0, 0, 8'd0, 8'd0, 4'b0000);
    idle(8'd0, 4'b0000);
    row(1, 0, 1, 0, 0, 8'd0, 8'd0, 4'b1100);
    row(0, 0, 1, 0, 0, 8'd0, 8'd0, 4'b1100);
    idle(8'd1, 4'b1000);
    row(0, 1, 0, 0, 0, 8'd0, 8'd0, 4'b0000);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 8'd0);
    #1;
    check("reset_state", 32'(obs), 32'h000);
    @(negedge clk);
    reset = 1'b0;

    // Default one-shot run with term=30.
    drive(1, 0, 0, 0, 0, 8'd0);
    tick();
    check("dflt_start", 32'(obs), {20'd0, 8'd0, 4'b1000});
    drive(0, 0, 0, 0, 0, 8'd0);
    for (int c = 1; c <= 29; c++) begin
      tick();
      check($sformatf("dflt_cnt%0d", c), 32'(obs), {20'd0, 8'(c), 4'b1000});
    end
    tick();
    check("dflt_expire30", 32'(obs), {20'd0, 8'd0, 4'b0011});
    tick();
    check("dflt_done", 32'(obs), {20'd0, 8'd0, 4'b0010});

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].ab, tbl[i].hd, tbl[i].pe, tbl[i].ld, tbl[i].lv);
      tick();
      check($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].exp_out));
    end

    // Asynchronous reset mid-count, then term must be back at 30.
    drive(1, 0, 0, 0, 0, 8'd0);
    tick();
    drive(0, 0, 0, 0, 0, 8'd0);
    tick(); tick(); tick();
    check("pre_rst_cnt3", 32'(obs), {20'd0, 8'd3, 4'b1000});
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_clear", 32'(obs), 32'h000);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 8'd0);
    tick();
    drive(0, 0, 0, 0, 0, 8'd0);
    cyc = 0;
    while (!expired && cyc < 60) begin
      tick();
      cyc++;
    end
    check("rst_term_back_30", 32'(cyc), 32'd30);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
